// File: rtl/id_pipe.sv
// ---------------------------------------------------------------------------
// id_pipe -- MIPS decode stage with integrated ID/EX pipeline register.
//
// Decodes one instruction per cycle, reads rs/rt from an internal register
// bank (write-first bypass from write-back), resolves BEQ/BNE in ID, detects
// load-use and branch-operand hazards, and registers all downstream controls
// and operands together with a valid bit.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_valid                 instruction / next_seq_pc valid in ID
//   i_instruction           instruction in ID (bits 31:0 decoded)
//   i_next_seq_pc           PC+4 of the instruction in ID
//   i_flush                 kill the instruction in ID
//   i_wb_write_enable/addr/data   register bank write-back port
//   o_stall                 hold IF and ID (combinational)
//   o_next_pc_src           branch taken (combinational)
//   o_next_not_seq_pc       branch target (combinational)
//   o_valid ... o_funct     registered ID/EX entry
//   o_bus_debug             flattened bank contents, register 0 in LSBs
// ---------------------------------------------------------------------------
module id_pipe #(
   parameter int REGISTERS_BANK_SIZE = 32,
   parameter int BUS_SIZE            = 32,
   parameter int PC_SIZE             = 32
) (
   input  logic                                    i_clk,
   input  logic                                    i_reset,
   input  logic                                    i_valid,
   input  logic [BUS_SIZE-1:0]                     i_instruction,
   input  logic [PC_SIZE-1:0]                      i_next_seq_pc,
   input  logic                                    i_flush,
   input  logic                                    i_wb_write_enable,
   input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]  i_wb_addr,
   input  logic [BUS_SIZE-1:0]                     i_wb_data,
   output logic                                    o_stall,
   output logic                                    o_next_pc_src,
   output logic [PC_SIZE-1:0]                      o_next_not_seq_pc,
   output logic                                    o_valid,
   output logic                                    o_wb_reg_write,
   output logic                                    o_wb_mem_to_reg,
   output logic                                    o_mem_read,
   output logic                                    o_mem_write,
   output logic                                    o_ex_dest,
   output logic                                    o_ex_alu_src,
   output logic [1:0]                              o_ex_alu_op,
   output logic [BUS_SIZE-1:0]                     o_bus_a,
   output logic [BUS_SIZE-1:0]                     o_bus_b,
   output logic [BUS_SIZE-1:0]                     o_imm_ext_signed,
   output logic [4:0]                              o_rs,
   output logic [4:0]                              o_rt,
   output logic [4:0]                              o_rd,
   output logic [5:0]                              o_funct,
   output logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0] o_bus_debug
);

   localparam int ADDR_W = $clog2(REGISTERS_BANK_SIZE);
   // Sign bits needed above imm16<<2 so the offset covers the full PC width.
   localparam int SEXT_W = (PC_SIZE > 18) ? PC_SIZE - 18 : 1;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       ex_dest;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       branch_eq;
      logic       branch_ne;
   } ctrl_t;

   // ------------------------------------------------------------------
   // Instruction fields
   // ------------------------------------------------------------------
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [15:0] imm;

   assign op    = i_instruction[31:26];
   assign rs    = i_instruction[25:21];
   assign rt    = i_instruction[20:16];
   assign rd    = i_instruction[15:11];
   assign funct = i_instruction[5:0];
   assign imm   = i_instruction[15:0];

   // Shift amount is carried inside funct-class instructions but not used here.
   logic unused_shamt;
   assign unused_shamt = ^i_instruction[10:6];

   generate
      if (BUS_SIZE > 32) begin : g_wide_instr
         logic unused_instr_hi;
         assign unused_instr_hi = ^i_instruction[BUS_SIZE-1:32];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   ctrl_t ctl;

   always_comb begin
      // NOTE: assign a default before the case so every path drives ctl; a
      // missing branch would otherwise infer a latch.
      ctl = '0;
      case (op)
         OP_RTYPE: begin
            ctl.reg_write = 1'b1;
            ctl.ex_dest   = 1'b1;
            ctl.alu_op    = 2'b10;
         end
         OP_LW: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.mem_read   = 1'b1;
            ctl.alu_src    = 1'b1;
         end
         OP_SW: begin
            ctl.mem_write = 1'b1;
            ctl.alu_src   = 1'b1;
         end
         OP_ADDI: begin
            ctl.reg_write = 1'b1;
            ctl.alu_src   = 1'b1;
         end
         OP_BEQ: begin
            ctl.branch_eq = 1'b1;
            ctl.alu_op    = 2'b01;
         end
         OP_BNE: begin
            ctl.branch_ne = 1'b1;
            ctl.alu_op    = 2'b01;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Register bank with write-first read bypass
   // ------------------------------------------------------------------
   logic [BUS_SIZE-1:0] regs [REGISTERS_BANK_SIZE];
   logic [ADDR_W-1:0]   rs_idx;
   logic [ADDR_W-1:0]   rt_idx;
   logic [BUS_SIZE-1:0] bus_a;
   logic [BUS_SIZE-1:0] bus_b;

   assign rs_idx = ADDR_W'(rs);
   assign rt_idx = ADDR_W'(rt);

   assign bus_a = (rs_idx == '0) ? '0 :
                  (i_wb_write_enable && i_wb_addr == rs_idx) ? i_wb_data : regs[rs_idx];
   assign bus_b = (rt_idx == '0) ? '0 :
                  (i_wb_write_enable && i_wb_addr == rt_idx) ? i_wb_data : regs[rt_idx];

   // NOTE: the bank is reset because its contents are architecturally visible
   // on o_bus_debug and must read back as zero after reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < REGISTERS_BANK_SIZE; i++) regs[i] <= '0;
      end else if (i_wb_write_enable && i_wb_addr != '0) begin
         regs[i_wb_addr] <= i_wb_data;
      end
   end

   generate
      for (genvar g = 0; g < REGISTERS_BANK_SIZE; g++) begin : g_debug
         assign o_bus_debug[g*BUS_SIZE +: BUS_SIZE] = regs[g];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   logic       shadow_valid;     // load one stage past ID/EX (MEM)
   logic [4:0] shadow_dest;
   logic [4:0] ex_dest_reg;
   logic       is_branch;
   logic       uses_rt;
   logic       load_use;
   logic       ex_writer;
   logic       branch_ex_hazard;
   logic       branch_mem_hazard;
   logic       advance;

   assign ex_dest_reg = o_ex_dest ? o_rd : o_rt;
   assign is_branch   = ctl.branch_eq | ctl.branch_ne;
   // rt is a source only for these; for LW/ADDI it is the destination.
   assign uses_rt     = (op == OP_RTYPE) || (op == OP_SW) || is_branch;

   assign load_use = o_valid && o_mem_read &&
                     ((ex_dest_reg == rs) || (uses_rt && ex_dest_reg == rt));

   assign ex_writer = o_valid && o_wb_reg_write && (ex_dest_reg != 5'd0);

   // Branches compare in ID, so any in-flight producer of rs/rt must drain
   // into the bank (and the bypass) before the compare is trusted.
   assign branch_ex_hazard  = is_branch && ex_writer &&
                              ((ex_dest_reg == rs) || (ex_dest_reg == rt));
   assign branch_mem_hazard = is_branch && shadow_valid &&
                              ((shadow_dest == rs) || (shadow_dest == rt));

   assign o_stall = i_valid && !i_flush &&
                    (load_use || branch_ex_hazard || branch_mem_hazard);

   assign o_next_pc_src = i_valid && !i_flush && !o_stall &&
                          ((ctl.branch_eq && (bus_a == bus_b)) ||
                           (ctl.branch_ne && (bus_a != bus_b)));

   assign o_next_not_seq_pc = i_next_seq_pc +
                              PC_SIZE'({{SEXT_W{imm[15]}}, imm, 2'b00});

   assign advance = i_valid && !i_flush && !o_stall;

   // ------------------------------------------------------------------
   // ID/EX register and load shadow
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, e.g. the shadow captures the old ID/EX entry.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         shadow_valid     <= 1'b0;
         shadow_dest      <= '0;
         o_valid          <= 1'b0;
         o_wb_reg_write   <= 1'b0;
         o_wb_mem_to_reg  <= 1'b0;
         o_mem_read       <= 1'b0;
         o_mem_write      <= 1'b0;
         o_ex_dest        <= 1'b0;
         o_ex_alu_src     <= 1'b0;
         o_ex_alu_op      <= '0;
         o_bus_a          <= '0;
         o_bus_b          <= '0;
         o_imm_ext_signed <= '0;
         o_rs             <= '0;
         o_rt             <= '0;
         o_rd             <= '0;
         o_funct          <= '0;
      end else begin
         // The EX stage never holds, so the entry moves to MEM every clock.
         shadow_valid <= o_valid && o_mem_read;
         shadow_dest  <= ex_dest_reg;
         if (advance) begin
            o_valid          <= 1'b1;
            o_wb_reg_write   <= ctl.reg_write;
            o_wb_mem_to_reg  <= ctl.mem_to_reg;
            o_mem_read       <= ctl.mem_read;
            o_mem_write      <= ctl.mem_write;
            o_ex_dest        <= ctl.ex_dest;
            o_ex_alu_src     <= ctl.alu_src;
            o_ex_alu_op      <= ctl.alu_op;
            o_bus_a          <= bus_a;
            o_bus_b          <= bus_b;
            o_imm_ext_signed <= {{(BUS_SIZE-16){imm[15]}}, imm};
            o_rs             <= rs;
            o_rt             <= rt;
            o_rd             <= rd;
            o_funct          <= funct;
         end else begin
            o_valid          <= 1'b0;
            o_wb_reg_write   <= 1'b0;
            o_wb_mem_to_reg  <= 1'b0;
            o_mem_read       <= 1'b0;
            o_mem_write      <= 1'b0;
            o_ex_dest        <= 1'b0;
            o_ex_alu_src     <= 1'b0;
            o_ex_alu_op      <= '0;
            o_bus_a          <= '0;
            o_bus_b          <= '0;
            o_imm_ext_signed <= '0;
            o_rs             <= '0;
            o_rt             <= '0;
            o_rd             <= '0;
            o_funct          <= '0;
         end
      end
   end

endmodule
